// File: rtl/arm_multicycle_mainfsm_if.sv
// Control bundle between the multicycle main FSM and the ARM datapath.
// The master side is the FSM: it reads the IR fields and drives every
// select, strobe and debug output.
interface arm_multicycle_mainfsm_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       Op;
  logic [5:0]       Funct;
  logic             IRWrite;
  logic             NextPC;
  logic             Branch;
  logic             RegW;
  logic             MemW;
  logic             AdrSrc;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ResultSrc;
  logic             ALUOp;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Op, Funct,
    output IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ALUOp, Illegal, State, InstrCount
  );

  modport slave (
    output Op, Funct,
    input  IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB,
           ResultSrc, ALUOp, Illegal, State, InstrCount
  );
endinterface

// File: rtl/arm_multicycle_mainfsm.sv
// Main sequencing FSM for the multicycle ARM datapath. Moore machine: all
// controls come from registers loaded with the decode of the next state, so
// they always reflect the current state. Adds read wait states, an illegal
// opcode trap and a retired-instruction counter.
module arm_multicycle_mainfsm #(
  parameter int MEM_WAIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  arm_multicycle_mainfsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  // Control word packing:
  // {IRWrite, NextPC, Branch, RegW, MemW, AdrSrc, ALUSrcA, ALUSrcB[1:0],
  //  ResultSrc[1:0], ALUOp, Illegal}
  localparam logic [12:0] CTL_FETCH = 13'b1_1_0_0_0_0_1_10_10_0_0;

  // Control word for each state; unlisted encodings drive everything low.
  function automatic logic [12:0] decodeCtl(input state_t st);
    logic [12:0] ctl;
    case (st)
      FETCH:    ctl = CTL_FETCH;
      DECODE:   ctl = 13'b0_0_0_0_0_0_1_10_10_0_0;
      MEMADR:   ctl = 13'b0_0_0_0_0_0_0_01_00_0_0;
      MEMREAD:  ctl = 13'b0_0_0_0_0_1_0_00_00_0_0;
      MEMWB:    ctl = 13'b0_0_0_1_0_0_0_00_01_0_0;
      MEMWRITE: ctl = 13'b0_0_0_0_1_1_0_00_00_0_0;
      EXECUTER: ctl = 13'b0_0_0_0_0_0_0_00_00_1_0;
      EXECUTEI: ctl = 13'b0_0_0_0_0_0_0_01_00_1_0;
      ALUWB:    ctl = 13'b0_0_0_1_0_0_0_00_00_0_0;
      BRANCH:   ctl = 13'b0_0_1_0_0_0_0_01_10_0_0;
      UNKNOWN:  ctl = 13'b0_0_0_0_0_0_0_00_00_0_1;
      default:  ctl = 13'b0_0_0_0_0_0_0_00_00_0_0;
    endcase
    return ctl;
  endfunction

  state_t           state_r;
  state_t           stateNext_s;
  logic [3:0]       waitCnt_r;
  logic [12:0]      ctl_r;
  logic [CNT_W-1:0] instrCount_r;
  logic             waitDone_s;
  logic             retire_s;
  logic             unusedFunct_s;

  // Only Funct[5] (I) and Funct[0] (L/S) steer the sequence.
  assign unusedFunct_s = ^bus.Funct[4:1];

  // Next-state decode, wait-state exit and retirement detection.
  always_comb begin
    waitDone_s  = (waitCnt_r == 4'(MEM_WAIT));
    retire_s    = 1'b0;
    stateNext_s = FETCH;
    case (state_r)
      FETCH:    stateNext_s = DECODE;
      DECODE: begin
        case (bus.Op)
          2'b00:   stateNext_s = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   stateNext_s = MEMADR;
          2'b10:   stateNext_s = BRANCH;
          default: stateNext_s = UNKNOWN;
        endcase
      end
      MEMADR:   stateNext_s = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:  stateNext_s = waitDone_s ? MEMWB : MEMREAD;
      MEMWB: begin
        stateNext_s = FETCH;
        retire_s    = 1'b1;
      end
      MEMWRITE: begin
        stateNext_s = FETCH;
        retire_s    = 1'b1;
      end
      EXECUTER: stateNext_s = ALUWB;
      EXECUTEI: stateNext_s = ALUWB;
      ALUWB: begin
        stateNext_s = FETCH;
        retire_s    = 1'b1;
      end
      BRANCH: begin
        stateNext_s = FETCH;
        retire_s    = 1'b1;
      end
      UNKNOWN:  stateNext_s = UNKNOWN;
      default:  stateNext_s = FETCH;
    endcase
  end

  // State, registered controls, wait counter and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= FETCH;
      ctl_r        <= CTL_FETCH;
      waitCnt_r    <= 4'd0;
      instrCount_r <= '0;
    end else begin
      state_r <= stateNext_s;
      ctl_r   <= decodeCtl(stateNext_s);
      // Counter is zero whenever MEMREAD is not occupied, so every entry starts at 0.
      if ((state_r == MEMREAD) && !waitDone_s) begin
        waitCnt_r <= waitCnt_r + 4'd1;
      end else begin
        waitCnt_r <= 4'd0;
      end
      if (retire_s) begin
        instrCount_r <= instrCount_r + CNT_W'(1);
      end else begin
        instrCount_r <= instrCount_r;
      end
    end
  end

  // Write strobes are held off while reset is asserted; selects keep FETCH values.
  assign bus.IRWrite    = ctl_r[12] & ~reset;
  assign bus.NextPC     = ctl_r[11] & ~reset;
  assign bus.Branch     = ctl_r[10] & ~reset;
  assign bus.RegW       = ctl_r[9]  & ~reset;
  assign bus.MemW       = ctl_r[8]  & ~reset;
  assign bus.AdrSrc     = ctl_r[7];
  assign bus.ALUSrcA    = ctl_r[6];
  assign bus.ALUSrcB    = ctl_r[5:4];
  assign bus.ResultSrc  = ctl_r[3:2];
  assign bus.ALUOp      = ctl_r[1];
  assign bus.Illegal    = ctl_r[0];
  assign bus.State      = state_r;
  assign bus.InstrCount = instrCount_r;

endmodule

// File: tb/tb_arm_multicycle_mainfsm.sv
// Directed bench for arm_multicycle_mainfsm. Instance A uses MEM_WAIT=2 and a
// 16-bit counter; instance B uses MEM_WAIT=0 and a 4-bit counter so the
// counter wrap can be reached in a short run.
module tb_arm_multicycle_mainfsm;

  logic clk;
  logic rstA;
  logic rstB;
  int   checks;
  int   errors;

  arm_multicycle_mainfsm_if #(.CNT_W(16)) busA ();
  arm_multicycle_mainfsm_if #(.CNT_W(4))  busB ();

  arm_multicycle_mainfsm #(.MEM_WAIT(2), .CNT_W(16)) dutA (
    .clk   (clk),
    .reset (rstA),
    .bus   (busA.master)
  );

  arm_multicycle_mainfsm #(.MEM_WAIT(0), .CNT_W(4)) dutB (
    .clk   (clk),
    .reset (rstB),
    .bus   (busB.master)
  );

  logic [12:0] ctlA;
  logic [12:0] ctlB;
  assign ctlA = {busA.IRWrite, busA.NextPC, busA.Branch, busA.RegW, busA.MemW,
                 busA.AdrSrc, busA.ALUSrcA, busA.ALUSrcB, busA.ResultSrc,
                 busA.ALUOp, busA.Illegal};
  assign ctlB = {busB.IRWrite, busB.NextPC, busB.Branch, busB.RegW, busB.MemW,
                 busB.AdrSrc, busB.ALUSrcA, busB.ALUSrcB, busB.ResultSrc,
                 busB.ALUOp, busB.Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control word per state, written out from the state table.
  function automatic logic [12:0] expCtl(input logic [3:0] st);
    case (st)
      4'd0:    return 13'b1_1_0_0_0_0_1_10_10_0_0;
      4'd1:    return 13'b0_0_0_0_0_0_1_10_10_0_0;
      4'd2:    return 13'b0_0_0_0_0_0_0_01_00_0_0;
      4'd3:    return 13'b0_0_0_0_0_1_0_00_00_0_0;
      4'd4:    return 13'b0_0_0_1_0_0_0_00_01_0_0;
      4'd5:    return 13'b0_0_0_0_1_1_0_00_00_0_0;
      4'd6:    return 13'b0_0_0_0_0_0_0_00_00_1_0;
      4'd7:    return 13'b0_0_0_0_0_0_0_01_00_1_0;
      4'd8:    return 13'b0_0_0_1_0_0_0_00_00_0_0;
      4'd9:    return 13'b0_0_1_0_0_0_0_01_10_0_0;
      4'd10:   return 13'b0_0_0_0_0_0_0_00_00_0_1;
      default: return 13'b0_0_0_0_0_0_0_00_00_0_0;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply an instruction while in FETCH and check n states (nibble i of seq = i-th state).
  task automatic runSeq(input bit useB, input string tag, input logic [1:0] op,
                        input logic [5:0] funct, input int n, input logic [31:0] seq);
    logic [3:0] st;
    if (useB) begin
      busB.Op = op;
      busB.Funct = funct;
    end else begin
      busA.Op = op;
      busA.Funct = funct;
    end
    for (int i = 0; i < n; i++) begin
      st = seq[4*i +: 4];
      checkVal($sformatf("%s_state%0d", tag, i), useB ? 32'(busB.State) : 32'(busA.State), 32'(st));
      checkVal($sformatf("%s_ctl%0d", tag, i), useB ? 32'(ctlB) : 32'(ctlA), 32'(expCtl(st)));
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rstA = 1'b1;
    rstB = 1'b1;
    busA.Op = 2'b00;
    busA.Funct = 6'b001000;
    busB.Op = 2'b00;
    busB.Funct = 6'b001000;
    repeat (3) @(negedge clk);

    // Reset held: FETCH selects, strobes low, counter clear.
    checkVal("rst_state", 32'(busA.State), 32'd0);
    checkVal("rst_ctl", 32'(ctlA), 32'(13'b0_0_0_0_0_0_1_10_10_0_0));
    checkVal("rst_cnt", 32'(busA.InstrCount), 32'd0);

    rstA = 1'b0;
    #1;
    runSeq(1'b0, "add", 2'b00, 6'b001000, 4, 32'h0000_8610);
    checkVal("add_cnt", 32'(busA.InstrCount), 32'd1);
    runSeq(1'b0, "addi", 2'b00, 6'b101000, 4, 32'h0000_8710);
    checkVal("addi_cnt", 32'(busA.InstrCount), 32'd2);
    runSeq(1'b0, "ldr", 2'b01, 6'b011001, 7, 32'h0433_3210);
    checkVal("ldr_cnt", 32'(busA.InstrCount), 32'd3);
    runSeq(1'b0, "str", 2'b01, 6'b011000, 4, 32'h0000_5210);
    checkVal("str_cnt", 32'(busA.InstrCount), 32'd4);
    runSeq(1'b0, "b", 2'b10, 6'b000000, 3, 32'h0000_0910);
    checkVal("b_cnt", 32'(busA.InstrCount), 32'd5);
    checkVal("b_back_fetch", 32'(busA.State), 32'd0);

    // Illegal opcode: trapped for 20 cycles, counter frozen.
    runSeq(1'b0, "ill", 2'b11, 6'b000000, 2, 32'h0000_0010);
    for (int i = 0; i < 20; i++) begin
      checkVal($sformatf("ill_state%0d", i), 32'(busA.State), 32'd10);
      checkVal($sformatf("ill_ctl%0d", i), 32'(ctlA), 32'(13'b0_0_0_0_0_0_0_00_00_0_1));
      @(negedge clk);
    end
    checkVal("ill_cnt", 32'(busA.InstrCount), 32'd5);
    rstA = 1'b1;
    #1;
    checkVal("ill_rst_state", 32'(busA.State), 32'd0);
    checkVal("ill_rst_illegal", 32'(busA.Illegal), 32'd0);
    @(negedge clk);
    rstA = 1'b0;
    #1;
    runSeq(1'b0, "add2", 2'b00, 6'b001000, 4, 32'h0000_8610);
    checkVal("add2_cnt", 32'(busA.InstrCount), 32'd1);

    // Reset in the middle of the MEMREAD wait.
    runSeq(1'b0, "ldrabt", 2'b01, 6'b011001, 5, 32'h0003_3210);
    rstA = 1'b1;
    #1;
    checkVal("abt_state", 32'(busA.State), 32'd0);
    checkVal("abt_cnt", 32'(busA.InstrCount), 32'd0);
    checkVal("abt_regw", 32'(busA.RegW), 32'd0);
    @(negedge clk);
    checkVal("abt_hold_state", 32'(busA.State), 32'd0);
    checkVal("abt_hold_regw", 32'(busA.RegW), 32'd0);
    rstA = 1'b0;
    #1;
    runSeq(1'b0, "add3", 2'b00, 6'b001000, 4, 32'h0000_8610);
    checkVal("add3_cnt", 32'(busA.InstrCount), 32'd1);

    // Instance B: zero wait states and counter wrap.
    rstB = 1'b0;
    #1;
    runSeq(1'b1, "ldr0", 2'b01, 6'b011001, 5, 32'h0004_3210);
    checkVal("ldr0_cnt", 32'(busB.InstrCount), 32'd1);
    for (int i = 0; i < 14; i++) begin
      runSeq(1'b1, "bw", 2'b10, 6'b000000, 3, 32'h0000_0910);
    end
    checkVal("wrap_pre_cnt", 32'(busB.InstrCount), 32'hF);
    runSeq(1'b1, "addw", 2'b00, 6'b001000, 4, 32'h0000_8610);
    checkVal("wrap_cnt", 32'(busB.InstrCount), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
